// File: rtl/rx_frame_controller.sv
// rx_frame_controller: 802.11a serial frame sequencer (preamble hunt, SIGNAL check, data gating).
// Build option RX_FRAME_CTRL_STRICT_EN: also reject frames with reserved bit 4 or tail bits 18-23 set.
module rx_frame_controller #(
    parameter int PREAMBLE_LEN = 96,
    parameter int MAX_LENGTH   = 4095
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Input,
    output logic [3:0]  Rate,
    output logic [11:0] Length,
    output logic        SignalValid,
    output logic        DataOut,
    output logic        DataValid,
    output logic        FrameDone,
    output logic        Busy,
    output logic        Error
);
    localparam int RUN_W = $clog2(PREAMBLE_LEN + 1);

    typedef enum logic [1:0] {HUNT, SIGNAL, DATA} state_t;

    state_t           state, state_d;
    logic [RUN_W-1:0] run_cnt, run_cnt_d;
    logic [4:0]       bit_cnt, bit_cnt_d;
    logic [14:0]      data_cnt, data_cnt_d;
    logic [23:0]      sig_sr, sig_sr_d;
    logic             prev_bit;
    logic [3:0]       rate_d;
    logic [11:0]      length_d;
    logic             sv_d, dout_d, dv_d, fd_d, err_d;
    logic [23:0]      sig_full;
    logic [11:0]      sig_len;
    logic             sig_ok;

    // Bit i of the SIGNAL field lands at index i once the current bit is included.
    assign sig_full = {Input, sig_sr[23:1]};
    assign sig_len  = sig_full[16:5];
    assign Busy     = (state != HUNT);

    always_comb begin
        sig_ok = ((^sig_full[17:0]) == 1'b0) && sig_full[3] && (sig_len != '0)
                 && (32'(sig_len) <= 32'(MAX_LENGTH));
`ifdef RX_FRAME_CTRL_STRICT_EN
        sig_ok = sig_ok && !sig_full[4] && (sig_full[23:18] == '0);
`endif
    end

    always_comb begin
        state_d    = state;
        run_cnt_d  = run_cnt;
        bit_cnt_d  = bit_cnt;
        data_cnt_d = data_cnt;
        sig_sr_d   = sig_sr;
        rate_d     = Rate;
        length_d   = Length;
        dout_d     = DataOut;
        sv_d       = 1'b0;
        dv_d       = 1'b0;
        fd_d       = 1'b0;
        err_d      = 1'b0;
        case (state)
            HUNT: begin
                // A zero count marks a fresh start: the first bit always opens a run.
                if (run_cnt != '0 && Input != prev_bit)
                    run_cnt_d = run_cnt + RUN_W'(1);
                else
                    run_cnt_d = RUN_W'(1);
                if (run_cnt_d == RUN_W'(PREAMBLE_LEN)) begin
                    state_d   = SIGNAL;
                    bit_cnt_d = '0;
                end
            end
            SIGNAL: begin
                sig_sr_d  = sig_full;
                bit_cnt_d = bit_cnt + 5'd1;
                if (bit_cnt == 5'd23) begin
                    if (sig_ok) begin
                        rate_d     = {sig_full[0], sig_full[1], sig_full[2], sig_full[3]};
                        length_d   = sig_len;
                        sv_d       = 1'b1;
                        data_cnt_d = {sig_len, 3'b000};
                        state_d    = DATA;
                    end else begin
                        err_d     = 1'b1;
                        run_cnt_d = '0;
                        state_d   = HUNT;
                    end
                end
            end
            DATA: begin
                dout_d     = Input;
                dv_d       = 1'b1;
                data_cnt_d = data_cnt - 15'd1;
                if (data_cnt == 15'd1) begin
                    fd_d      = 1'b1;
                    run_cnt_d = '0;
                    state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= HUNT;
            run_cnt     <= '0;
            bit_cnt     <= '0;
            data_cnt    <= '0;
            sig_sr      <= '0;
            prev_bit    <= 1'b0;
            Rate        <= '0;
            Length      <= '0;
            SignalValid <= 1'b0;
            DataOut     <= 1'b0;
            DataValid   <= 1'b0;
            FrameDone   <= 1'b0;
            Error       <= 1'b0;
        end else begin
            state       <= state_d;
            run_cnt     <= run_cnt_d;
            bit_cnt     <= bit_cnt_d;
            data_cnt    <= data_cnt_d;
            sig_sr      <= sig_sr_d;
            prev_bit    <= Input;
            Rate        <= rate_d;
            Length      <= length_d;
            SignalValid <= sv_d;
            DataOut     <= dout_d;
            DataValid   <= dv_d;
            FrameDone   <= fd_d;
            Error       <= err_d;
        end
    end
endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: frame-level vector table, timing sequences, and a
// randomized bit stream checked against a stream-parsing reference model.
module tb_rx_frame_controller;
    localparam int PRE  = 96;
    localparam int MAXL = 4095;

    logic        Clock, Reset, Input;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic        SignalValid, DataOut, DataValid, FrameDone, Busy, Error;

    rx_frame_controller #(.PREAMBLE_LEN(PRE), .MAX_LENGTH(MAXL)) dut (
        .Clock(Clock), .Reset(Reset), .Input(Input), .Rate(Rate), .Length(Length),
        .SignalValid(SignalValid), .DataOut(DataOut), .DataValid(DataValid),
        .FrameDone(FrameDone), .Busy(Busy), .Error(Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cnt_sv, cnt_err, cnt_dv, cnt_fd;
    bit stim[$];
    logic [21:0] exp_o[$];

    always @(negedge Clock) begin
        if (SignalValid) cnt_sv++;
        if (Error)       cnt_err++;
        if (DataValid)   cnt_dv++;
        if (FrameDone)   cnt_fd++;
    end

    typedef struct {
        int          pre1;
        logic [3:0]  rate;
        logic [11:0] len;
        bit          pflip;
        bit          res;
        logic [5:0]  tail;
        int          e_sv, e_err, e_dv, e_fd;
        logic [3:0]  e_rate;
        logic [11:0] e_len;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [21:0] outs();
        return {Rate, Length, SignalValid, DataOut, DataValid, FrameDone, Busy, Error};
    endfunction

    task automatic drive_bit(input bit b);
        Input = b;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Input = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        cnt_sv = 0; cnt_err = 0; cnt_dv = 0; cnt_fd = 0;
    endtask

    task automatic play();
        foreach (stim[k]) drive_bit(stim[k]);
        stim.delete();
    endtask

    task automatic add_pre(input int n, input bit first);
        for (int k = 0; k < n; k++) stim.push_back(first ^ k[0]);
    endtask

    task automatic add_sig(input logic [3:0] rate, input logic [11:0] len, input bit pflip,
                           input bit res, input logic [5:0] tail);
        bit s[24];
        bit p;
        for (int m = 0; m < 24; m++) s[m] = 1'b0;
        for (int m = 0; m < 4; m++) s[m] = rate[3-m];
        s[4] = res;
        for (int m = 0; m < 12; m++) s[5+m] = len[m];
        p = 1'b0;
        for (int m = 0; m < 17; m++) p ^= s[m];
        s[17] = p ^ pflip;
        for (int m = 0; m < 6; m++) s[18+m] = tail[m];
        for (int m = 0; m < 24; m++) stim.push_back(s[m]);
    endtask

    task automatic add_rand(input int n);
        for (int k = 0; k < n; k++) stim.push_back(1'($urandom_range(0, 1)));
    endtask

    function automatic bit alt_run(input int a, input int b);
        for (int m = a + 1; m <= b; m++)
            if (stim[m] == stim[m-1]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: scan the whole stream for a 96-bit alternating window that starts no
    // earlier than the re-arm point, then judge the next 24 bits and gate the payload.
    task automatic model_run();
        int n;
        int i, j, e, last;
        bit sv[], er[], dv[], fd[], bz[], up[];
        logic [3:0]  ur[];
        logic [11:0] ul[];
        bit s[24];
        bit p, ok;
        logic [11:0] ln;
        logic [3:0]  r;
        logic [11:0] l;
        logic        d;
        n = stim.size();
        sv = new[n]; er = new[n]; dv = new[n]; fd = new[n]; bz = new[n]; up = new[n];
        ur = new[n]; ul = new[n];
        i = 0;
        while (i < n) begin
            j = -1;
            for (int k = i + PRE - 1; k < n; k++)
                if (alt_run(k - PRE + 1, k)) begin j = k; break; end
            if (j < 0) break;
            for (int k = j; k < n && k < j + 24; k++) bz[k] = 1'b1;
            if (j + 24 >= n) break;
            for (int m = 0; m < 24; m++) s[m] = stim[j+1+m];
            e = j + 24;
            p = 1'b0;
            for (int m = 0; m < 18; m++) p ^= s[m];
            for (int m = 0; m < 12; m++) ln[m] = s[5+m];
            ok = !p && s[3] && (ln >= 1) && (ln <= MAXL);
`ifdef RX_FRAME_CTRL_STRICT_EN
            ok = ok && !s[4];
            for (int m = 18; m < 24; m++) if (s[m]) ok = 1'b0;
`endif
            if (!ok) begin
                er[e] = 1'b1;
                i = e + 1;
            end else begin
                sv[e] = 1'b1; bz[e] = 1'b1; up[e] = 1'b1;
                ur[e] = {s[0], s[1], s[2], s[3]};
                ul[e] = ln;
                last = e + 8 * int'(ln);
                for (int k = e + 1; k <= last && k < n; k++) begin
                    dv[k] = 1'b1;
                    bz[k] = (k != last);
                    fd[k] = (k == last);
                end
                i = last + 1;
            end
        end
        r = '0; l = '0; d = 1'b0;
        exp_o.delete();
        for (int k = 0; k < n; k++) begin
            if (up[k]) begin r = ur[k]; l = ul[k]; end
            if (dv[k]) d = stim[k];
            exp_o.push_back({r, l, sv[k], d, dv[k], fd[k], bz[k], er[k]});
        end
    endtask

    vec_t vt[8];

    initial begin
        bit st;
        bit lastb;
        bit dq[$];
        int nz, pl;
        logic [3:0]  rr;
        logic [11:0] ll;
        logic [5:0]  tl;

        vt[0] = '{0,  4'b1101, 12'd128, 1'b0, 1'b0, 6'd0, 1, 0, 1024, 1, 4'b1101, 12'd128};
        vt[1] = '{0,  4'b1101, 12'd128, 1'b1, 1'b0, 6'd0, 0, 1, 0,    0, 4'b0000, 12'd0};
        vt[2] = '{50, 4'b1011, 12'd1,   1'b0, 1'b0, 6'd0, 1, 0, 8,    1, 4'b1011, 12'd1};
        vt[3] = '{0,  4'b1100, 12'd5,   1'b0, 1'b0, 6'd0, 0, 1, 0,    0, 4'b0000, 12'd0};
        vt[4] = '{0,  4'b1111, 12'd0,   1'b0, 1'b0, 6'd0, 0, 1, 0,    0, 4'b0000, 12'd0};
        vt[7] = '{0,  4'b0001, 12'd2,   1'b0, 1'b0, 6'd0, 1, 0, 16,   1, 4'b0001, 12'd2};
`ifdef RX_FRAME_CTRL_STRICT_EN
        vt[5] = '{0,  4'b0101, 12'd2,   1'b0, 1'b0, 6'b000100, 0, 1, 0, 0, 4'b0000, 12'd0};
        vt[6] = '{0,  4'b0111, 12'd3,   1'b0, 1'b1, 6'd0,      0, 1, 0, 0, 4'b0000, 12'd0};
`else
        vt[5] = '{0,  4'b0101, 12'd2,   1'b0, 1'b0, 6'b000100, 1, 0, 16, 1, 4'b0101, 12'd2};
        vt[6] = '{0,  4'b0111, 12'd3,   1'b0, 1'b1, 6'd0,      1, 0, 24, 1, 4'b0111, 12'd3};
`endif
        Reset = 1'b1;
        Input = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        for (int v = 0; v < 8; v++) begin
            do_reset();
            st = 1'b1;
            if (vt[v].pre1 > 0) begin
                add_pre(vt[v].pre1, 1'b1);
                st = stim[stim.size()-1];
            end
            add_pre(PRE, st);
            add_sig(vt[v].rate, vt[v].len, vt[v].pflip, vt[v].res, vt[v].tail);
            add_rand(8 * int'(vt[v].len));
            for (int k = 0; k < 4; k++) stim.push_back(1'b0);
            play();
            check($sformatf("vec%0d_sv", v),   cnt_sv,  vt[v].e_sv);
            check($sformatf("vec%0d_err", v),  cnt_err, vt[v].e_err);
            check($sformatf("vec%0d_dv", v),   cnt_dv,  vt[v].e_dv);
            check($sformatf("vec%0d_fd", v),   cnt_fd,  vt[v].e_fd);
            check($sformatf("vec%0d_rate", v), Rate,    vt[v].e_rate);
            check($sformatf("vec%0d_len", v),  Length,  vt[v].e_len);
        end

        // Cycle-exact timing of lock, SIGNAL acceptance, payload and frame end.
        do_reset();
        check("reset_outs", outs(), 22'd0);
        add_pre(PRE, 1'b1);
        for (int k = 0; k < PRE - 1; k++) drive_bit(stim[k]);
        check("busy_before_lock", Busy, 1'b0);
        drive_bit(stim[PRE-1]);
        check("busy_at_lock", Busy, 1'b1);
        stim.delete();
        add_sig(4'b1001, 12'd3, 1'b0, 1'b0, 6'd0);
        for (int k = 0; k < 23; k++) drive_bit(stim[k]);
        check("sv_before_bit23", cnt_sv, 0);
        drive_bit(stim[23]);
        stim.delete();
        check("sv_at_bit23", SignalValid, 1'b1);
        check("rate_at_bit23", Rate, 4'b1001);
        check("len_at_bit23", Length, 12'd3);
        check("busy_after_sig", Busy, 1'b1);
        lastb = 1'b0;
        for (int k = 0; k < 24; k++) begin
            lastb = 1'($urandom_range(0, 1));
            drive_bit(lastb);
            check("data_dv_dout", {DataValid, DataOut}, {1'b1, lastb});
            check("data_fd", FrameDone, (k == 23));
        end
        drive_bit(~lastb);
        check("after_frame", {DataValid, FrameDone, Busy, DataOut}, {3'b000, lastb});
        check("sv_once", cnt_sv, 1);

        // Parity failure: Error right after bit 23, and the block is idle at once.
        do_reset();
        add_pre(PRE, 1'b1);
        add_sig(4'b1101, 12'd128, 1'b1, 1'b0, 6'd0);
        play();
        check("perr_error", {Error, SignalValid, Busy}, 3'b100);
        drive_bit(1'b0);
        check("perr_pulse_end", Error, 1'b0);

        // Back-to-back frames with no idle bit between them.
        do_reset();
        add_pre(PRE, 1'b1);
        add_sig(4'b1011, 12'd1, 1'b0, 1'b0, 6'd0);
        add_rand(8);
        add_pre(PRE, 1'b1);
        add_sig(4'b0011, 12'd2, 1'b0, 1'b0, 6'd0);
        add_rand(16);
        for (int k = 0; k < 4; k++) stim.push_back(1'b0);
        play();
        check("b2b_sv", cnt_sv, 2);
        check("b2b_dv", cnt_dv, 24);
        check("b2b_fd", cnt_fd, 2);
        check("b2b_err", cnt_err, 0);
        check("b2b_len", Length, 12'd2);

        // Reset in the middle of DATA aborts silently.
        do_reset();
        add_pre(PRE, 1'b1);
        add_sig(4'b1101, 12'd4, 1'b0, 1'b0, 6'd0);
        add_rand(10);
        play();
        check("mid_busy", Busy, 1'b1);
        Reset = 1'b1;
        drive_bit(1'b1);
        Reset = 1'b0;
        check("mid_reset_outs", outs(), 22'd0);
        for (int k = 0; k < 40; k++) stim.push_back(1'b0);
        play();
        check("mid_reset_fd", cnt_fd, 0);
        check("mid_reset_err", cnt_err, 0);
        check("mid_reset_dv", cnt_dv, 10);

        // Randomized stream against the reference model.
        do_reset();
        for (int f = 0; f < 10; f++) begin
            nz = $urandom_range(0, 12);
            add_rand(nz);
            pl = PRE + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            add_pre(pl, 1'($urandom_range(0, 1)));
            rr = 4'($urandom);
            if ($urandom_range(0, 3) != 0) rr[0] = 1'b1;
            ll = 12'($urandom_range(0, 5));
            tl = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
            add_sig(rr, ll, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), tl);
            add_rand(8 * int'(ll));
        end
        for (int k = 0; k < 40; k++) stim.push_back(1'b0);
        model_run();
        foreach (stim[k]) begin
            drive_bit(stim[k]);
            check($sformatf("rand_cyc%0d", k), outs(), exp_o[k]);
        end
        stim.delete();
        dq.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
